// File: rtl/baud_tick_gen_if.sv
// baud_tick_gen_if: control/status bundle between the register block (master)
// and the baud tick generator (slave).
//   en, mode, sel, div_i, restart : master -> generator controls
//   os_tick, bit_tick, baud_clk   : generator -> engines, one-cycle strobes / monitor
//   div_clamped, div_eff          : generator -> register block status
interface baud_tick_gen_if #(
    parameter int DIV_W = 16
);
    logic             en;
    logic             mode;
    logic [1:0]       sel;
    logic [DIV_W-1:0] div_i;
    logic             restart;
    logic             os_tick;
    logic             bit_tick;
    logic             baud_clk;
    logic             div_clamped;
    logic [DIV_W-1:0] div_eff;

    modport master (
        output en, mode, sel, div_i, restart,
        input  os_tick, bit_tick, baud_clk, div_clamped, div_eff
    );

    modport slave (
        input  en, mode, sel, div_i, restart,
        output os_tick, bit_tick, baud_clk, div_clamped, div_eff
    );
endinterface

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: single-clock baud divider producing enable strobes.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : baud_tick_gen_if.slave
//     os_tick  - one-cycle strobe every div_eff clocks
//     bit_tick - one-cycle strobe every OVERSAMPLE os_ticks
//     baud_clk - registered square wave, period OVERSAMPLE*div_eff
//     div_clamped / div_eff - status of the divisor in use
// The divisor is only reloaded at a period boundary (or while disabled, or on
// restart), so divisor changes never produce runt or stretched periods.
module baud_tick_gen #(
    parameter int DIV_W      = 16,
    parameter int OVERSAMPLE = 16,
    parameter int DIV0       = 208,
    parameter int DIV1       = 104,
    parameter int DIV2       = 52,
    parameter int DIV3       = 26
) (
    input logic           clk,
    input logic           rst_n,
    baud_tick_gen_if.slave bus
);
    localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [DIV_W-1:0] D_MIN  = DIV_W'(2);

    logic [DIV_W-1:0] cyc_cnt;
    logic [OS_W-1:0]  os_cnt;
    logic [DIV_W-1:0] div_eff;
    logic             div_clamped;
    logic             os_tick;
    logic             bit_tick;
    logic             baud_clk;

    logic [DIV_W-1:0] d_raw;
    logic [DIV_W-1:0] d_new;
    logic             clamp_new;

    // Candidate divisor; below 2 the strobes would merge, so floor it at 2.
    always_comb begin
        d_raw = DIV_W'(DIV0);
        if (bus.mode) begin
            d_raw = bus.div_i;
        end else begin
            case (bus.sel)
                2'd0:    d_raw = DIV_W'(DIV0);
                2'd1:    d_raw = DIV_W'(DIV1);
                2'd2:    d_raw = DIV_W'(DIV2);
                default: d_raw = DIV_W'(DIV3);
            endcase
        end
        clamp_new = (d_raw < D_MIN);
        d_new     = clamp_new ? D_MIN : d_raw;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_cnt     <= DIV_W'(DIV0 - 1);
            os_cnt      <= '0;
            div_eff     <= DIV_W'(DIV0);
            div_clamped <= 1'b0;
            os_tick     <= 1'b0;
            bit_tick    <= 1'b0;
            baud_clk    <= 1'b0;
        end else if (!bus.en || bus.restart) begin
            // Hold at phase 0 with a fresh divisor; restart beats a
            // coincident boundary, so no tick is issued here.
            cyc_cnt     <= d_new - 1'b1;
            div_eff     <= d_new;
            div_clamped <= clamp_new;
            os_cnt      <= '0;
            os_tick     <= 1'b0;
            bit_tick    <= 1'b0;
            baud_clk    <= 1'b0;
        end else if (cyc_cnt == '0) begin
            cyc_cnt     <= d_new - 1'b1;
            div_eff     <= d_new;
            div_clamped <= clamp_new;
            os_tick     <= 1'b1;
            if (os_cnt == OS_LAST) begin
                os_cnt   <= '0;
                bit_tick <= 1'b1;
            end else begin
                os_cnt   <= os_cnt + 1'b1;
                bit_tick <= 1'b0;
            end
            // Rise at mid-bit, fall together with bit_tick.
            if (os_cnt == OS_HALF || os_cnt == OS_LAST) begin
                baud_clk <= ~baud_clk;
            end
        end else begin
            cyc_cnt  <= cyc_cnt - 1'b1;
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
        end
    end

    assign bus.os_tick     = os_tick;
    assign bus.bit_tick    = bit_tick;
    assign bus.baud_clk    = baud_clk;
    assign bus.div_clamped = div_clamped;
    assign bus.div_eff     = div_eff;
endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen with hand-computed cycle counts.
module tb_baud_tick_gen;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   n;
    int   sum;

    baud_tick_gen_if #(.DIV_W(16)) bus ();

    baud_tick_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // what: 0 os_tick, 1 bit_tick, 2 baud_clk high, 3 baud_clk low.
    // Returns edges stepped until the condition is seen, -1 on timeout.
    task automatic wait_for(input int what, output int cnt);
        bit hit;
        hit = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5000 && !hit; i++) begin
            step();
            cnt++;
            case (what)
                0:       hit = bus.os_tick;
                1:       hit = bus.bit_tick;
                2:       hit = bus.baud_clk;
                default: hit = !bus.baud_clk;
            endcase
        end
        if (!hit) cnt = -1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b0; bus.mode = 1'b0; bus.sel = 2'd0;
        bus.div_i = '0; bus.restart = 1'b0;

        // Reset state
        step(); step();
        chk("rst_os_tick", bus.os_tick, 0);
        chk("rst_bit_tick", bus.bit_tick, 0);
        chk("rst_baud_clk", bus.baud_clk, 0);
        chk("rst_clamped", bus.div_clamped, 0);
        chk("rst_div_eff", bus.div_eff, 208);

        // Preset sweep; a sel change right after bit_tick lets the in-flight
        // 'old' period finish before the new divisor applies.
        rst_n = 1'b1; bus.en = 1'b1;
        wait_for(1, n); chk("sel0_first_bit", n, 3328);
        chk("sel0_baud_fall", bus.baud_clk, 0);
        wait_for(1, n); chk("sel0_bit", n, 3328);
        chk("sel0_div_eff", bus.div_eff, 208);
        bus.sel = 2'd1;
        wait_for(1, n); chk("sel1_switch_bit", n, 208 + 15 * 104);
        wait_for(1, n); chk("sel1_bit", n, 1664);
        chk("sel1_div_eff", bus.div_eff, 104);
        bus.sel = 2'd2;
        wait_for(1, n); chk("sel2_switch_bit", n, 104 + 15 * 52);
        wait_for(1, n); chk("sel2_bit", n, 832);
        bus.sel = 2'd3;
        wait_for(1, n); chk("sel3_switch_bit", n, 52 + 15 * 26);
        wait_for(1, n); chk("sel3_bit", n, 416);
        chk("sel3_div_eff", bus.div_eff, 26);

        // Boundary switch mid-period
        bus.sel = 2'd0; bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        wait_for(0, n); chk("bnd_first_os", n, 208);
        repeat (100) step();
        bus.sel = 2'd3;
        wait_for(0, n); chk("bnd_inflight_os", n, 108);
        wait_for(0, n); chk("bnd_new_os", n, 26);

        // Programmable divisor and clamping
        bus.mode = 1'b1; bus.div_i = 16'd5;
        wait_for(0, n); chk("prog_old_os", n, 26);
        wait_for(0, n); chk("prog5_os", n, 5);
        chk("prog5_clamped", bus.div_clamped, 0);
        chk("prog5_div_eff", bus.div_eff, 5);
        bus.div_i = 16'd1;
        wait_for(0, n); chk("prog1_old_os", n, 5);
        wait_for(0, n); chk("prog1_os", n, 2);
        chk("prog1_clamped", bus.div_clamped, 1);
        chk("prog1_div_eff", bus.div_eff, 2);
        bus.div_i = 16'd0;
        wait_for(0, n); chk("prog0_os_a", n, 2);
        wait_for(0, n); chk("prog0_os_b", n, 2);
        chk("prog0_clamped", bus.div_clamped, 1);

        // restart coincident with cyc_cnt==0
        bus.div_i = 16'd10; bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        sum = 0;
        for (int i = 0; i < 56; i++) begin
            wait_for(0, n);
            sum += n;
        end
        chk("rs_3p5_bits", sum, 560);
        chk("rs_baud_high", bus.baud_clk, 1);
        repeat (9) step();
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        chk("rs_no_os", bus.os_tick, 0);
        chk("rs_no_bit", bus.bit_tick, 0);
        chk("rs_baud_low", bus.baud_clk, 0);
        wait_for(0, n); chk("rs_first_os", n, 10);
        wait_for(2, n); chk("rs_baud_rise", n, 70);
        wait_for(1, n); chk("rs_bit", n, 80);

        // baud_clk shape with div 4
        bus.div_i = 16'd4; bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        wait_for(2, n); chk("shape_low0", n, 32);
        wait_for(3, n); chk("shape_high", n, 32);
        chk("shape_bit_at_fall", bus.bit_tick, 1);
        wait_for(2, n); chk("shape_low", n, 32);

        // Disable mid-bit
        repeat (5) step();
        bus.en = 1'b0;
        step();
        chk("dis_os", bus.os_tick, 0);
        chk("dis_bit", bus.bit_tick, 0);
        chk("dis_baud", bus.baud_clk, 0);
        bus.en = 1'b1;
        wait_for(0, n); chk("dis_first_os", n, 4);
        wait_for(2, n); chk("dis_baud_rise", n, 28);

        // Reset mid-run
        repeat (3) step();
        rst_n = 1'b0;
        step();
        chk("mrst_os", bus.os_tick, 0);
        chk("mrst_baud", bus.baud_clk, 0);
        chk("mrst_div_eff", bus.div_eff, 208);
        rst_n = 1'b1; bus.en = 1'b0;
        step();
        chk("mrst_load_div", bus.div_eff, 4);
        bus.en = 1'b1;
        wait_for(0, n); chk("mrst_first_os", n, 4);
        wait_for(2, n); chk("mrst_baud_rise", n, 28);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
